// File: rtl/acam_fifo_reader.sv
// Readout engine for the ACAM TDC FIFO1: watches the empty flag, runs the
// chip-select/read-strobe cycle and buffers each 28-bit word into a small stream FIFO.
module acam_fifo_reader #(
  parameter int unsigned g_rd_pulse_cycles = 2,
  parameter int unsigned g_recovery_cycles = 4,
  parameter int unsigned g_fifo_log2       = 2,
  parameter logic [3:0]  g_fifo1_addr      = 4'd8
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        ef1_i,
  input  logic [27:0] data_i,
  output logic        cs_n_o,
  output logic        rd_n_o,
  output logic [3:0]  addr_o,
  output logic [27:0] ts_data_o,
  output logic        ts_valid_o,
  input  logic        ts_ready_i,
  output logic [31:0] rd_count_o,
  output logic        busy_o
);

  localparam int unsigned DATA_W     = 28;
  localparam int unsigned PTR_W      = g_fifo_log2 + 1;
  localparam logic [7:0]  PULSE_LAST = 8'(g_rd_pulse_cycles - 1);
  localparam logic [7:0]  RECOV_LAST = 8'(g_recovery_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_LATCH,
    S_RECOVER
  } state_t;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_cs_n;
  logic              r_rd_n;
  logic [3:0]        r_addr;
  logic              r_busy;
  logic [31:0]       r_rd_count;

  logic              r_ef1_meta_p0;
  logic              r_ef1_s_p1;
  logic [DATA_W-1:0] r_word_p1;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_strobe_end;
  logic [DATA_W-1:0] r_mem [0:(1 << g_fifo_log2)-1];

  // ---- p0/p1: empty-flag synchronizer (resets to "empty") ----
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_ef1_meta_p0 <= 1'b1;
      r_ef1_s_p1    <= 1'b1;
    end else begin
      r_ef1_meta_p0 <= ef1_i;
      r_ef1_s_p1    <= r_ef1_meta_p0;
    end
  end

  assign w_level      = r_wr_ptr - r_rd_ptr;
  assign w_full       = w_level[PTR_W-1];
  assign w_empty      = (w_level == '0);
  assign w_push       = (r_state == S_LATCH) && !w_full;
  assign w_pop        = !w_empty && ts_ready_i;
  assign w_strobe_end = (r_state == S_STROBE) && (r_cnt == PULSE_LAST);

  // ---- access sequencer ----
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cs_n  <= 1'b1;
      r_rd_n  <= 1'b1;
      r_addr  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Only one access is ever in flight, so checking fullness here is enough.
          if (enable_i && !r_ef1_s_p1 && !w_full) begin
            r_state <= S_SETUP;
            r_cs_n  <= 1'b0;
            r_addr  <= g_fifo1_addr;
            r_busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_rd_n  <= 1'b0;
          r_cnt   <= '0;
        end
        S_STROBE: begin
          if (r_cnt == PULSE_LAST) begin
            r_state <= S_LATCH;
            r_rd_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_LATCH: begin
          r_state <= S_RECOVER;
          r_cs_n  <= 1'b1;
          r_addr  <= '0;
          r_cnt   <= '0;
        end
        S_RECOVER: begin
          if (r_cnt == RECOV_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cs_n  <= 1'b1;
          r_rd_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- p1: capture the bus on the edge that ends the strobe ----
  always_ff @(posedge clk_sys_i) begin
    if (w_strobe_end) begin
      r_word_p1 <= data_i;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_rd_count <= '0;
    end else if (r_state == S_LATCH) begin
      r_rd_count <= r_rd_count + 32'd1;
    end
  end

  // ---- p2: stream FIFO; storage is not reset, only the pointers ----
  always_ff @(posedge clk_sys_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[g_fifo_log2-1:0]] <= r_word_p1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign cs_n_o     = r_cs_n;
  assign rd_n_o     = r_rd_n;
  assign addr_o     = r_addr;
  assign busy_o     = r_busy;
  assign rd_count_o = r_rd_count;
  assign ts_valid_o = !w_empty;
  assign ts_data_o  = w_empty ? '0 : r_mem[r_rd_ptr[g_fifo_log2-1:0]];

endmodule
